// File: rtl/axi4lite_regbank_if.sv
`default_nettype none
// ============================================================================
//  axi4lite_regbank_if
//  AXI4-Lite bus bundle between the interconnect master and the register bank.
//  Revision: 1.0
// ============================================================================
interface axi4lite_regbank_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic                    S_AXI_AWVALID;
    logic                    S_AXI_AWREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                    S_AXI_WVALID;
    logic                    S_AXI_WREADY;
    logic [1:0]              S_AXI_BRESP;
    logic                    S_AXI_BVALID;
    logic                    S_AXI_BREADY;
    logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic                    S_AXI_ARVALID;
    logic                    S_AXI_ARREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]              S_AXI_RRESP;
    logic                    S_AXI_RVALID;
    logic                    S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
               S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
               S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
               S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
               S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface
`default_nettype wire

// File: rtl/axi4lite_regbank.sv
`default_nettype none
// ============================================================================
//  axi4lite_regbank
//  Parametrised AXI4-Lite register bank: N_RW control + N_RO status registers.
//  Optional wr_pulse output enabled by AXI_REGBANK_PULSE_EN.
//  Revision: 1.0
// ============================================================================
module axi4lite_regbank #(
    parameter int                      N_RW       = 4,
    parameter int                      N_RO       = 4,
    parameter int                      DATA_WIDTH = 32,
    parameter int                      ADDR_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0]   RESET_VAL  = '0
) (
    input  wire logic                                           ACLK,
    input  wire logic                                           ARESET,
    axi4lite_regbank_if.slave                                   s_axi,
    output logic [N_RW*DATA_WIDTH-1:0]                          rw_regs,
`ifdef AXI_REGBANK_PULSE_EN
    output logic [N_RW-1:0]                                     wr_pulse,
`endif
    input  wire logic [((N_RO > 0) ? N_RO : 1)*DATA_WIDTH-1:0]  ro_regs
);

    localparam int         STRB_W   = DATA_WIDTH / 8;
    localparam int         ADDR_LSB = $clog2(STRB_W);
    localparam logic [1:0] C_OKAY   = 2'b00;
    localparam logic [1:0] C_SLVERR = 2'b10;

    typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_t;
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

    wstate_t                r_wstate;
    rstate_t                r_rstate;
    logic [DATA_WIDTH-1:0]  r_regs [N_RW];

    logic                   r_awready, r_wready, r_aw_held, r_w_held, r_bvalid;
    logic [1:0]             r_bresp;
    logic [ADDR_WIDTH-1:0]  r_awaddr;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [STRB_W-1:0]      r_wstrb;

    logic                   r_arready, r_rvalid;
    logic [1:0]             r_rresp;
    logic [DATA_WIDTH-1:0]  r_rdata;

    logic                   w_aw_fire, w_w_fire, w_ar_fire, w_wr_ok;
    logic [ADDR_WIDTH-1:0]  w_awaddr, w_widx, w_ridx;
    logic [DATA_WIDTH-1:0]  w_wdata, w_rd_data;
    logic [STRB_W-1:0]      w_wstrb;
    logic [1:0]             w_rd_resp;

    assign w_aw_fire = s_axi.S_AXI_AWVALID && r_awready;
    assign w_w_fire  = s_axi.S_AXI_WVALID  && r_wready;
    assign w_ar_fire = s_axi.S_AXI_ARVALID && r_arready;

    // A channel captured in an earlier cycle wins over the live bus value.
    assign w_awaddr = r_aw_held ? r_awaddr : s_axi.S_AXI_AWADDR;
    assign w_wdata  = r_w_held  ? r_wdata  : s_axi.S_AXI_WDATA;
    assign w_wstrb  = r_w_held  ? r_wstrb  : s_axi.S_AXI_WSTRB;
    assign w_widx   = w_awaddr >> ADDR_LSB;
    assign w_wr_ok  = (w_widx < ADDR_WIDTH'(N_RW));
    assign w_ridx   = s_axi.S_AXI_ARADDR >> ADDR_LSB;

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = C_SLVERR;
        for (int i = 0; i < N_RW; i++) begin
            if (w_ridx == ADDR_WIDTH'(i)) begin
                w_rd_data = r_regs[i];
                w_rd_resp = C_OKAY;
            end
        end
        for (int j = 0; j < N_RO; j++) begin
            if (w_ridx == ADDR_WIDTH'(N_RW + j)) begin
                w_rd_data = ro_regs[j*DATA_WIDTH +: DATA_WIDTH];
                w_rd_resp = C_OKAY;
            end
        end
    end

`ifdef AXI_REGBANK_PULSE_EN
    logic [N_RW-1:0] r_pulse;
    assign wr_pulse = r_pulse;
`endif

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= C_OKAY;
            for (int i = 0; i < N_RW; i++) r_regs[i] <= RESET_VAL;
`ifdef AXI_REGBANK_PULSE_EN
            r_pulse   <= '0;
`endif
        end else begin
`ifdef AXI_REGBANK_PULSE_EN
            r_pulse <= '0;
`endif
            case (r_wstate)
                W_IDLE: begin
                    if ((r_aw_held || w_aw_fire) && (r_w_held || w_w_fire)) begin
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        r_bvalid  <= 1'b1;
                        r_bresp   <= w_wr_ok ? C_OKAY : C_SLVERR;
                        r_wstate  <= W_RESP;
                        for (int i = 0; i < N_RW; i++) begin
                            if (w_widx == ADDR_WIDTH'(i)) begin
                                for (int b = 0; b < STRB_W; b++) begin
                                    if (w_wstrb[b]) r_regs[i][b*8 +: 8] <= w_wdata[b*8 +: 8];
                                end
`ifdef AXI_REGBANK_PULSE_EN
                                r_pulse[i] <= 1'b1;
`endif
                            end
                        end
                    end else begin
                        if (w_aw_fire) begin
                            r_aw_held <= 1'b1;
                            r_awaddr  <= s_axi.S_AXI_AWADDR;
                        end
                        if (w_w_fire) begin
                            r_w_held <= 1'b1;
                            r_wdata  <= s_axi.S_AXI_WDATA;
                            r_wstrb  <= s_axi.S_AXI_WSTRB;
                        end
                        r_awready <= !(r_aw_held || w_aw_fire);
                        r_wready  <= !(r_w_held || w_w_fire);
                    end
                end
                W_RESP: begin
                    if (s_axi.S_AXI_BREADY) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= C_OKAY;
            r_rdata   <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_fire) begin
                        r_rdata   <= w_rd_data;
                        r_rresp   <= w_rd_resp;
                        r_rvalid  <= 1'b1;
                        r_arready <= 1'b0;
                        r_rstate  <= R_DATA;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi.S_AXI_RREADY) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign s_axi.S_AXI_AWREADY = r_awready;
    assign s_axi.S_AXI_WREADY  = r_wready;
    assign s_axi.S_AXI_BVALID  = r_bvalid;
    assign s_axi.S_AXI_BRESP   = r_bresp;
    assign s_axi.S_AXI_ARREADY = r_arready;
    assign s_axi.S_AXI_RVALID  = r_rvalid;
    assign s_axi.S_AXI_RRESP   = r_rresp;
    assign s_axi.S_AXI_RDATA   = r_rdata;

    generate
        for (genvar gi = 0; gi < N_RW; gi++) begin : g_pack
            assign rw_regs[gi*DATA_WIDTH +: DATA_WIDTH] = r_regs[gi];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_axi4lite_regbank.sv
`default_nettype none
// ============================================================================
//  tb_axi4lite_regbank
//  Directed and randomized transactions checked against an array-based model.
//  Revision: 1.0
// ============================================================================
module tb_axi4lite_regbank;
    localparam int N_RW = 4;
    localparam int N_RO = 4;
    localparam int DW   = 32;
    localparam int AW   = 8;

    logic                 ACLK   = 1'b0;
    logic                 ARESET = 1'b1;
    logic [N_RW*DW-1:0]   rw_regs;
    logic [N_RO*DW-1:0]   ro_regs;
`ifdef AXI_REGBANK_PULSE_EN
    logic [N_RW-1:0]      wr_pulse;
`endif

    axi4lite_regbank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi4lite_regbank #(
        .N_RW(N_RW), .N_RO(N_RO), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_VAL('0)
    ) dut (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .s_axi    (bus),
        .rw_regs  (rw_regs),
`ifdef AXI_REGBANK_PULSE_EN
        .wr_pulse (wr_pulse),
`endif
        .ro_regs  (ro_regs)
    );

    always #5 ACLK = ~ACLK;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_rw [N_RW];
    logic [1:0]  exp_bresp;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        checks++;
        errors++;
        $error("FAIL %s timeout observed=no_handshake expected=handshake", tag);
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    function automatic logic [1:0] model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
        if (idx >= N_RW) return 2'b10;
        for (int b = 0; b < 4; b++)
            if (s[b]) m_rw[idx][b*8 +: 8] = d[b*8 +: 8];
        return 2'b00;
    endfunction

    task automatic model_read(input int idx, output logic [31:0] d, output logic [1:0] r);
        if (idx < N_RW) begin
            d = m_rw[idx]; r = 2'b00;
        end else if (idx < N_RW + N_RO) begin
            d = ro_regs[(idx-N_RW)*DW +: DW]; r = 2'b00;
        end else begin
            d = '0; r = 2'b10;
        end
    endtask

    function automatic logic [127:0] model_pack();
        logic [127:0] p;
        for (int i = 0; i < N_RW; i++) p[i*32 +: 32] = m_rw[i];
        return p;
    endfunction

    // Leaves the bank in W_RESP so the caller can stall BREADY arbitrarily.
    task automatic write_issue(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                               input int aw_dly, input int w_dly, input string tag);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int cyc = 0;
        int idx;
        bus.S_AXI_AWADDR = addr;
        bus.S_AXI_WDATA  = data;
        bus.S_AXI_WSTRB  = strb;
        while (!(aw_done && w_done) && cyc < 40) begin
            bus.S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
            bus.S_AXI_WVALID  = !w_done  && (cyc >= w_dly);
            aw_hs = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
            w_hs  = bus.S_AXI_WVALID  && bus.S_AXI_WREADY;
            check({tag, "_bvalid_early"}, bus.S_AXI_BVALID, 1'b0);
            tick();
            cyc++;
            aw_done |= aw_hs;
            w_done  |= w_hs;
        end
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        if (!(aw_done && w_done)) begin
            timeout_fail(tag);
            return;
        end
        idx = int'(addr) / 4;
        exp_bresp = model_write(idx, data, strb);
        check({tag, "_bvalid"}, bus.S_AXI_BVALID, 1'b1);
        check({tag, "_bresp"}, bus.S_AXI_BRESP, exp_bresp);
        check({tag, "_rw_regs"}, rw_regs, model_pack());
`ifdef AXI_REGBANK_PULSE_EN
        check({tag, "_pulse"}, wr_pulse, (exp_bresp == 2'b00) ? (4'b1 << idx) : 4'b0);
`endif
    endtask

    task automatic write_resp(input int stall, input string tag);
        for (int k = 0; k < stall; k++) begin
            tick();
            check({tag, "_bvalid_hold"}, bus.S_AXI_BVALID, 1'b1);
            check({tag, "_bresp_hold"}, bus.S_AXI_BRESP, exp_bresp);
`ifdef AXI_REGBANK_PULSE_EN
            check({tag, "_pulse_off"}, wr_pulse, 4'b0);
`endif
        end
        bus.S_AXI_BREADY = 1'b1;
        tick();
        bus.S_AXI_BREADY = 1'b0;
        check({tag, "_bvalid_clr"}, bus.S_AXI_BVALID, 1'b0);
        check({tag, "_awready"}, {bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 2'b11);
`ifdef AXI_REGBANK_PULSE_EN
        check({tag, "_pulse_off"}, wr_pulse, 4'b0);
`endif
    endtask

    task automatic read_txn(input logic [AW-1:0] addr, input int stall, input string tag);
        logic [31:0] ed;
        logic [1:0]  er;
        int cyc = 0;
        bus.S_AXI_ARADDR  = addr;
        bus.S_AXI_ARVALID = 1'b1;
        while (!bus.S_AXI_ARREADY && cyc < 40) begin
            tick();
            cyc++;
        end
        if (!bus.S_AXI_ARREADY) begin
            bus.S_AXI_ARVALID = 1'b0;
            timeout_fail(tag);
            return;
        end
        model_read(int'(addr) / 4, ed, er);
        tick();
        bus.S_AXI_ARVALID = 1'b0;
        check({tag, "_rvalid"}, bus.S_AXI_RVALID, 1'b1);
        check({tag, "_rdata"}, bus.S_AXI_RDATA, ed);
        check({tag, "_rresp"}, bus.S_AXI_RRESP, er);
        for (int k = 0; k < stall; k++) begin
            tick();
            check({tag, "_rdata_hold"}, {bus.S_AXI_RVALID, bus.S_AXI_RRESP, bus.S_AXI_RDATA}, {1'b1, er, ed});
        end
        bus.S_AXI_RREADY = 1'b1;
        tick();
        bus.S_AXI_RREADY = 1'b0;
        check({tag, "_rvalid_clr"}, bus.S_AXI_RVALID, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old_val;
        logic [AW-1:0] ra;
        int ridx;
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 0; bus.S_AXI_WDATA = '0;
        bus.S_AXI_WSTRB = '0;  bus.S_AXI_WVALID = 0;  bus.S_AXI_BREADY = 0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARVALID = 0; bus.S_AXI_RREADY = 0;
        ro_regs = '0;
        for (int i = 0; i < N_RW; i++) m_rw[i] = '0;

        // Reset state
        tick(); tick();
        check("rst_ready", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b000);
        check("rst_valid", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 2'b00);
        check("rst_resp", {bus.S_AXI_BRESP, bus.S_AXI_RRESP, bus.S_AXI_RDATA}, '0);
        check("rst_regs", rw_regs, '0);
`ifdef AXI_REGBANK_PULSE_EN
        check("rst_pulse", wr_pulse, 4'b0);
`endif
        ARESET = 1'b0;
        tick();
        check("rel_ready", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b111);

        // Basic write/read-back
        for (int i = 0; i < 4; i++) begin
            write_issue(AW'(i*4), 32'(i+1), 4'hF, 0, 0, "wr_basic");
            write_resp(0, "wr_basic");
        end
        for (int i = 0; i < 4; i++) read_txn(AW'(i*4), 0, "rd_basic");

        // Byte strobes, both channel orderings
        write_issue(8'h00, 32'h11223344, 4'hF, 0, 0, "wr_base"); write_resp(0, "wr_base");
        write_issue(8'h00, 32'hAABBCCDD, 4'b0101, 0, 0, "wr_strb"); write_resp(1, "wr_strb");
        check("strb_value", rw_regs[31:0], 32'h11BB33DD);
        read_txn(8'h00, 1, "rd_strb");
        write_issue(8'h00, 32'h11223344, 4'hF, 0, 0, "wr_base2"); write_resp(0, "wr_base2");
        write_issue(8'h00, 32'hAABBCCDD, 4'b0101, 3, 0, "wr_w_first"); write_resp(0, "wr_w_first");
        check("w_first_value", rw_regs[31:0], 32'h11BB33DD);
        write_issue(8'h04, 32'h0BADBEEF, 4'hF, 0, 2, "wr_aw_first"); write_resp(0, "wr_aw_first");

        // Read-only and unmapped
        ro_regs[31:0] = 32'hCAFEF00D;
        read_txn(8'h10, 0, "rd_ro");
        write_issue(8'h10, 32'h12345678, 4'hF, 0, 0, "wr_ro"); write_resp(0, "wr_ro");
        check("wr_ro_bresp", exp_bresp, 2'b10);
        read_txn(8'h10, 0, "rd_ro_after");
        read_txn(8'h20, 0, "rd_unmapped");
        write_issue(8'h24, 32'h12345678, 4'hF, 1, 0, "wr_unmapped"); write_resp(0, "wr_unmapped");

        // B backpressure with a concurrent read
        write_issue(8'h00, 32'h5A5A5A5A, 4'hF, 0, 0, "wr_stall");
        read_txn(8'h04, 2, "rd_concurrent");
        check("stall_bvalid", {bus.S_AXI_BVALID, bus.S_AXI_BRESP}, 3'b100);
        write_resp(10, "wr_stall");

        // Same-edge write commit and read of register 2
        old_val = m_rw[2];
        bus.S_AXI_AWADDR = 8'h08; bus.S_AXI_WDATA = 32'h55667788; bus.S_AXI_WSTRB = 4'hF;
        bus.S_AXI_ARADDR = 8'h08;
        bus.S_AXI_AWVALID = 1; bus.S_AXI_WVALID = 1; bus.S_AXI_ARVALID = 1;
        check("coll_ready", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b111);
        tick();
        bus.S_AXI_AWVALID = 0; bus.S_AXI_WVALID = 0; bus.S_AXI_ARVALID = 0;
        exp_bresp = model_write(2, 32'h55667788, 4'hF);
        check("coll_rdata", {bus.S_AXI_RVALID, bus.S_AXI_RDATA}, {1'b1, old_val});
        check("coll_bvalid", bus.S_AXI_BVALID, 1'b1);
        check("coll_regs", rw_regs, model_pack());
`ifdef AXI_REGBANK_PULSE_EN
        check("coll_pulse", wr_pulse, 4'b0100);
`endif
        bus.S_AXI_BREADY = 1; bus.S_AXI_RREADY = 1;
        tick();
        bus.S_AXI_BREADY = 0; bus.S_AXI_RREADY = 0;
        check("coll_done", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 2'b00);
        read_txn(8'h08, 0, "rd_coll_new");

        // Reset after AW captured, before W
        bus.S_AXI_AWADDR = 8'h04; bus.S_AXI_AWVALID = 1;
        tick();
        bus.S_AXI_AWVALID = 0;
        bus.S_AXI_ARADDR = 8'h00; bus.S_AXI_ARVALID = 1;
        tick();
        bus.S_AXI_ARVALID = 0;
        #2;
        ARESET = 1'b1;
        #1;
        for (int i = 0; i < N_RW; i++) m_rw[i] = '0;
        check("mid_rst_valid", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 2'b00);
        check("mid_rst_ready", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b000);
        check("mid_rst_regs", rw_regs, '0);
        tick(); tick();
        ARESET = 1'b0;
        tick();
        check("mid_rel_ready", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b111);
        write_issue(8'h04, 32'hDEAD0004, 4'hF, 3, 0, "wr_after_rst"); write_resp(0, "wr_after_rst");
        read_txn(8'h04, 0, "rd_after_rst");

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            ro_regs = {$urandom, $urandom, $urandom, $urandom};
            ridx = $urandom_range(0, 11);
            ra = AW'(ridx*4 + $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                write_issue(ra, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                            $urandom_range(0, 3), "rnd_wr");
                write_resp($urandom_range(0, 2), "rnd_wr");
            end else begin
                read_txn(ra, $urandom_range(0, 2), "rnd_rd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/axi4lite_regbank.md
# axi4lite_regbank

Parametrised AXI4-Lite slave register bank: the next generation of our fixed four-register AXI4-Lite slave. It provides N_RW software-writable control registers, N_RO read-only status registers and byte-strobe writes. Out-of-range and read-only writes return SLVERR, and write and read channels run independently. It sits between the PS/interconnect AXI master and the analog front-end control logic, which consumes `rw_regs` and drives `ro_regs`.

## Interface
- `N_RW`, 4: number of read/write registers (1–64).
- `N_RO`, 4: number of read-only registers (0–64).
- `DATA_WIDTH`, 32: register and AXI data width; 32 or 64.
- `ADDR_WIDTH`, 8: AXI address width; must hold `(N_RW+N_RO)*DATA_WIDTH/8`.
- `RESET_VAL`, 0: reset value of every RW register (`DATA_WIDTH` bits).

Ports:
- `ACLK` in 1: single clock.
- `ARESET` in 1: reset, asynchronous, active-high.
- `S_AXI_AWADDR` in ADDR_WIDTH, `S_AXI_AWVALID` in 1, `S_AXI_AWREADY` out 1: write address channel.
- `S_AXI_WDATA` in DATA_WIDTH, `S_AXI_WSTRB` in DATA_WIDTH/8, `S_AXI_WVALID` in 1, `S_AXI_WREADY` out 1: write data channel.
- `S_AXI_BRESP` out 2, `S_AXI_BVALID` out 1, `S_AXI_BREADY` in 1: write response channel.
- `S_AXI_ARADDR` in ADDR_WIDTH, `S_AXI_ARVALID` in 1, `S_AXI_ARREADY` out 1: read address channel.
- `S_AXI_RDATA` out DATA_WIDTH, `S_AXI_RRESP` out 2, `S_AXI_RVALID` out 1, `S_AXI_RREADY` in 1: read data channel.
- `rw_regs` out N_RW*DATA_WIDTH: RW register contents; register i at bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `ro_regs` in max(N_RO,1)*DATA_WIDTH: status inputs; same packing.
- `wr_pulse` out N_RW: present only with `AXI_REGBANK_PULSE_EN`.

## Operation
- **Address map.** Index = `ADDR >> log2(DATA_WIDTH/8)`; low address bits are ignored.
  - Indices 0..N_RW-1: RW.
  - Indices N_RW..N_RW+N_RO-1: RO.
  - Higher indices: unmapped.
- **Write FSM, states W_IDLE and W_RESP.**
  - W_IDLE: AW and W are captured independently, in either order or in the same cycle. A channel's ready deasserts once it has been captured.
  - When both are held, the write commits and the FSM enters W_RESP.
  - Commit: per byte lane, the register updates only where the WSTRB bit is 1. RW index gives OKAY (00). RO or unmapped index gives SLVERR (10) with no state change.
  - W_RESP: BVALID=1 until BREADY; then return to W_IDLE with AWREADY=WREADY=1.
- **Read FSM, states R_IDLE and R_DATA.**
  - R_IDLE: ARREADY=1. On the AR handshake, capture RDATA/RRESP and enter R_DATA.
  - RW/RO index returns its value with OKAY. Unmapped index returns RDATA=0 with SLVERR.
  - R_DATA: ARREADY=0, RVALID=1. RDATA and RRESP stay stable until RREADY, then return to R_IDLE.
- Read and write FSMs are fully concurrent.
- `ro_regs` is sampled at the AR handshake edge only.

## Timing
- **Reset values:**
  - AWREADY, WREADY, ARREADY = 0 while ARESET is high. They are 1 from the first ACLK edge after release.
  - BVALID = RVALID = 0; BRESP = RRESP = 00; RDATA = 0.
  - `rw_regs` = RESET_VAL; `wr_pulse` = 0.
- **Write latency:** BVALID and the `rw_regs` update appear on the edge following the cycle in which the second of AW/W is accepted (1 cycle).
- **Read latency:** RVALID appears 1 cycle after the AR handshake. Back-to-back throughput: one read per 2 cycles with RREADY held high.
- **Same-edge collision:** if a write commit and an AR handshake to the same register land on the same edge, the read returns the old value.
- **Stalls:** BREADY or RREADY held low stalls its own FSM indefinitely, with no data loss. The other channel keeps running.
- **Reset mid-transaction:** ARESET asserted at any point aborts the transaction. Captured AW/W/AR are discarded, all valids clear immediately, and registers return to RESET_VAL. No response is issued.

## Configuration
- `AXI_REGBANK_PULSE_EN` defined:
  - Adds the `wr_pulse` port. Bit i is high for exactly one cycle, coincident with the `rw_regs` update, on every OKAY write to RW index i (including WSTRB=0).
  - SLVERR writes produce no pulse.
- Not defined: the `wr_pulse` port and its logic are absent. All other behaviour is identical.

## Test plan
- **Reset and read-back:** defaults with RESET_VAL=0, N_RW=4, N_RO=4. Write 0x1..0x4 to addresses 0x0,0x4,0x8,0xC, then read them back. Expect 0x1..0x4 with OKAY, and BVALID exactly 1 cycle after the AW/W handshake.
- **Byte strobes and channel ordering:**
  - Write 0xAABBCCDD to 0x0 with WSTRB=0b0101 over an old value of 0x11223344. Expect a read of 0x11BB33DD.
  - Repeat with W arriving 3 cycles before AW. Same result.
- **Read-only and unmapped:**
  - Drive `ro_regs[0]`=0xCAFEF00D and read 0x10. Expect 0xCAFEF00D with OKAY.
  - Write to 0x10. Expect SLVERR and the value unchanged.
  - Read 0x20. Expect RDATA=0 with SLVERR.
- **Backpressure and concurrency:**
  - Hold BREADY=0 for 10 cycles. BVALID stays 1 and BRESP stays stable.
  - A concurrent read of 0x4 completes meanwhile with the correct data.
  - A same-edge write/read to 0x8 returns the old value.
- **Reset mid-write:**
  - Assert ARESET after the AW handshake but before W. All valids return to 0 and `rw_regs` returns to RESET_VAL.
  - A subsequent complete write succeeds normally.
- **With `AXI_REGBANK_PULSE_EN`:**
  - A write to 0x8 gives `wr_pulse`=0b0100 for exactly 1 cycle.
  - A SLVERR write to 0x10 gives no pulse.
